// File: rtl/prism_cfg_shift_ctrl.sv
// PRISM config-chain write sequencer: stages two bus writes into one word, then
// sweeps non-overlapping one-hot latch enables from the tail stage to the head stage.
module prism_cfg_shift_ctrl #(
  parameter int WIDTH      = 48,
  parameter int DEPTH      = 8,
  parameter int EN_CYCLES  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_req,
  input  logic [5:0]       address,
  input  logic [31:0]      data_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] config_data,
  output logic [DEPTH-1:0] latch_en,
  output logic             busy,
  output logic             overrun_err,
  output logic [7:0]       load_count
);

  localparam int HI_W  = WIDTH - 32;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX  = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [5:0] ADDR_LO = 6'h08;
  localparam logic [5:0] ADDR_HI = 6'h0C;

  typedef enum logic [1:0] {IDLE, EN, GAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      lo_q, lo_d;
  logic [HI_W-1:0]  hi_q, hi_d;
  logic [DEPTH-1:0] latch_en_q, latch_en_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic [7:0]       load_q, load_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    latch_en_d = latch_en_q;
    busy_d     = busy_q;
    ovr_d      = ovr_q;
    load_d     = load_q;

    // A write during a sweep must not disturb the word being shifted; flag it instead.
    if (write_req && busy_q)  ovr_d = 1'b1;
    else if (clear_err)       ovr_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (write_req && address == ADDR_LO) begin
          lo_d = data_in;
        end else if (write_req && address == ADDR_HI) begin
          hi_d                = data_in[HI_W-1:0];
          state_d             = EN;
          idx_d               = IDX_W'(DEPTH - 1);
          cnt_d               = '0;
          busy_d              = 1'b1;
          latch_en_d          = '0;
          latch_en_d[DEPTH-1] = 1'b1;
        end
      end
      EN: begin
        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
          state_d    = GAP;
          cnt_d      = '0;
          latch_en_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d                    = idx_q - 1'b1;
            state_d                  = EN;
            latch_en_d               = '0;
            latch_en_d[idx_q - 1'b1] = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (load_q != 8'hFF) load_d = load_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        latch_en_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= IDX_W'(DEPTH - 1);
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      latch_en_q <= '0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      load_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      latch_en_q <= latch_en_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      load_q     <= load_d;
    end
  end

  assign config_data = {hi_q, lo_q};
  assign latch_en    = latch_en_q;
  assign busy        = busy_q;
  assign overrun_err = ovr_q;
  assign load_count  = load_q;

endmodule

// File: tb/tb_prism_cfg_shift_ctrl.sv
// Directed bench for prism_cfg_shift_ctrl: default instance plus an EN=2/GAP=3 instance.
module tb_prism_cfg_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, write_req, write_req2, clear_err;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [47:0] config_data, config_data2;
  logic [7:0]  latch_en, latch_en2;
  logic        busy, busy2, overrun_err, overrun_err2;
  logic [7:0]  load_count, load_count2;

  int checks = 0;
  int passed = 0;
  int viol   = 0;
  logic [47:0] chain [8];
  logic [47:0] words [8];

  always #5 clk = ~clk;

  prism_cfg_shift_ctrl dut (
    .clk(clk), .rst_n(rst_n), .write_req(write_req), .address(address),
    .data_in(data_in), .clear_err(clear_err), .config_data(config_data),
    .latch_en(latch_en), .busy(busy), .overrun_err(overrun_err),
    .load_count(load_count)
  );

  prism_cfg_shift_ctrl #(.EN_CYCLES(2), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .write_req(write_req2), .address(address),
    .data_in(data_in), .clear_err(clear_err), .config_data(config_data2),
    .latch_en(latch_en2), .busy(busy2), .overrun_err(overrun_err2),
    .load_count(load_count2)
  );

  // Latch-chain model: stage k copies k-1 while enabled, stage 0 copies config_data.
  always @(negedge clk) begin
    for (int k = 7; k >= 0; k--)
      if (latch_en[k]) chain[k] = (k == 0) ? config_data : chain[k-1];
    if ($countones(latch_en) > 1 || (!busy && latch_en != 8'h00)) viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    write_req = 1'b1; address = a; data_in = d;
    tick();
    write_req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] exp_en;
    rst_n = 1'b0; write_req = 0; write_req2 = 0; clear_err = 0; address = '0; data_in = '0;
    do_reset();
    check("reset_cfg", config_data, 48'h0);
    check("reset_en", latch_en, 8'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_ovr", overrun_err, 1'b0);
    check("reset_cnt", load_count, 8'h0);

    // Basic load: exact one-hot/gap pattern for 16 cycles
    wr(6'h08, 32'hDEADBEEF);
    wr(6'h0C, 32'h0000CAFE);
    check("cfg_word", config_data, 48'hCAFEDEADBEEF);
    for (int i = 0; i < 16; i++) begin
      exp_en = (i % 2 == 0) ? (8'h80 >> (i / 2)) : 8'h00;
      check($sformatf("sweep_en[%0d]", i), latch_en, exp_en);
      check($sformatf("sweep_busy[%0d]", i), busy, 1'b1);
      tick();
    end
    check("sweep_done_busy", busy, 1'b0);
    check("sweep_done_en", latch_en, 8'h0);
    check("load_cnt_1", load_count, 8'd1);

    // Eight loads fill the chain, newest at stage 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      words[i] = {8'hA0, 8'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101};
      wr(6'h08, words[i][31:0]);
      wr(6'h0C, {16'h0, words[i][47:32]});
      wait_idle(n);
      check($sformatf("load%0d_len", i), n, 16);
    end
    check("load_cnt_8", load_count, 8'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("chain[%0d]", k), chain[k], words[7-k]);
    check("onehot_viol", viol, 0);

    // Commit on the very cycle busy fell is accepted
    wr(6'h0C, 32'h0000BEEF);
    check("b2b_busy", busy, 1'b1);
    check("b2b_en", latch_en, 8'h80);
    wait_idle(n);
    check("b2b_len", n, 16);
    check("load_cnt_9", load_count, 8'd9);

    // Overrun at sweep cycle 5
    do_reset();
    wr(6'h08, 32'h01234567);
    wr(6'h0C, 32'h000089AB);
    repeat (4) tick();
    wr(6'h0C, 32'h00001234);
    check("ovr_set", overrun_err, 1'b1);
    check("ovr_cfg", config_data, 48'h89AB01234567);
    wait_idle(n);
    check("ovr_len", n + 5, 16);
    check("ovr_cfg_end", config_data, 48'h89AB01234567);
    check("ovr_sticky", overrun_err, 1'b1);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    check("ovr_cleared", overrun_err, 1'b0);
    wr(6'h0C, 32'h00005555);
    write_req = 1'b1; clear_err = 1'b1; address = 6'h08; data_in = 32'hFFFFFFFF;
    tick();
    write_req = 1'b0; clear_err = 1'b0;
    check("ovr_set_wins", overrun_err, 1'b1);
    check("ovr_lo_kept", config_data, 48'h555501234567);
    wait_idle(n);

    // EN_CYCLES=2, GAP_CYCLES=3 instance
    address = 6'h0C; data_in = 32'h00000042; write_req2 = 1'b1;
    tick();
    write_req2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      exp_en = (i % 5 < 2) ? (8'h80 >> (i / 5)) : 8'h00;
      check($sformatf("p2_en[%0d]", i), latch_en2, exp_en);
      check($sformatf("p2_busy[%0d]", i), busy2, 1'b1);
      tick();
    end
    check("p2_done", busy2, 1'b0);
    check("p2_cnt", load_count2, 8'd1);

    // Reset mid-sweep aborts
    do_reset();
    wr(6'h08, 32'hAAAA5555);
    wr(6'h0C, 32'h00003333);
    repeat (6) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("abort_en", latch_en, 8'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_cfg", config_data, 48'h0);
    check("abort_cnt", load_count, 8'd0);
    wr(6'h08, 32'h0000_0001);
    wr(6'h0C, 32'h0000_0002);
    wait_idle(n);
    check("abort_reload_len", n, 16);
    check("abort_reload_cnt", load_count, 8'd1);

    // Low write and a foreign address never start a sweep
    do_reset();
    wr(6'h08, 32'h11111111);
    check("lo_only_busy", busy, 1'b0);
    wr(6'h04, 32'hFFFFFFFF);
    check("addr04_busy", busy, 1'b0);
    check("addr04_en", latch_en, 8'h0);
    check("addr04_cfg", config_data, 48'h000011111111);
    tick();
    check("addr04_busy_later", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
